// File: rtl/rr_arbiter_5_pkg.sv
// Shared definitions for the five-requester round-robin arbiter (package arb_pkg).
// The optional forced-release feature is selected by the ARB_TIMEOUT_EN macro.
package arb_pkg;

  localparam int N_REQ      = 5;
  localparam int HOLD_CNT_W = 8;
  localparam int PTR_W      = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter_5_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_5_if;
  import arb_pkg::*;

  // Handshake: each requester holds its req bit high until it has been served.
  // grant is registered and is either all-zero or one-hot. grant_valid is high
  // exactly when grant is non-zero. The holder keeps the grant while its req bit
  // stays high, and gives it back either by dropping req or by pulsing
  // release_pulse for one cycle. Every grant is followed by at least one idle
  // cycle. A release_pulse seen while nothing is granted is ignored.
  logic [N_REQ-1:0] req;
  logic             release_pulse;
  logic [N_REQ-1:0] grant;
  logic             grant_valid;
  logic             timeout;

  modport master (output req, release_pulse, input grant, grant_valid, timeout);
  modport slave  (input req, release_pulse, output grant, grant_valid, timeout);

endinterface

// File: rtl/rr_arbiter_5_rr_pick.sv
// Rotating find-first-set: the first set req bit scanning ptr, ptr+1, ..., wrapping at 4.
module rr_pick
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W-1:0] start;
  logic [3:0]       pos;

  // Out-of-range pointer values cannot be produced by the arbiter; fold them to 0.
  assign start = (ptr > PTR_W'(N_REQ - 1)) ? '0 : ptr;

  always_comb begin
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, start} + 4'(k);
      if (pos >= 4'(N_REQ)) pos = pos - 4'(N_REQ);
      if (!any && req[pos[PTR_W-1:0]]) begin
        any = 1'b1;
        idx = pos[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_5.sv
// Five-requester round-robin arbiter with a registered one-hot grant.
// Defining ARB_TIMEOUT_EN adds forced release after HOLD_MAX held cycles.
module rr_arbiter_5
  import arb_pkg::*;
#(
  parameter int HOLD_MAX = 15
) (
  input  logic            clk,
  input  logic            reset,
  rr_arbiter_5_if.slave   bus,
  output state_t          state
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
    $error("HOLD_MAX must be in 1..255");
  end

  state_t           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] gidx_q, gidx_d;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_any;
  logic             done;
  logic             force_rel;

  rr_pick u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign done = bus.release_pulse || !bus.req[gidx_q];

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;
  logic                  timeout_q, timeout_d;

  assign force_rel = (state_q == GRANT) && (hold_q == HOLD_CNT_W'(HOLD_MAX - 1));

  always_comb begin
    hold_d    = hold_q;
    timeout_d = 1'b0;
    if (state_q == IDLE) begin
      hold_d = '0;
    end else begin
      // A voluntary release in the same cycle wins and is not reported as a timeout.
      timeout_d = force_rel && !done;
      if (hold_q != '1) hold_d = hold_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = GRANT;
          grant_d = onehot(pick_idx);
          gidx_d  = pick_idx;
        end
      end
      GRANT: begin
        // Ending always passes through IDLE, giving the encoder an all-zero cycle.
        if (done || force_rel) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (gidx_q == PTR_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = |grant_q;
  assign state           = state_q;

endmodule

// File: tb/tb_rr_arbiter_5.sv
// Bench for rr_arbiter_5: directed vectors, a cycle model of the round-robin rules,
// and literal expectations. Works with or without ARB_TIMEOUT_EN.
module tb_rr_arbiter_5;
  import arb_pkg::*;

  localparam int HOLD = 4;

  logic   clk;
  logic   reset;
  state_t dut_state;
  int     total;
  int     bad;

  rr_arbiter_5_if bus ();

  rr_arbiter_5 #(.HOLD_MAX(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dut_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- reference model + expected queue ----------------
  int         m_holder;
  int         m_ptr;
  int         m_cycles;
  logic       m_to;
  logic       started;
  logic [5:0] exp_q[$];

  initial begin
    m_holder = -1;
    m_ptr    = 0;
    m_cycles = 0;
    m_to     = 1'b0;
    started  = 1'b0;
  end

  always @(posedge clk) begin : model
    int   pick;
    int   nh, np, nc;
    logic nt;
    logic fin, forced;
    nh = m_holder; np = m_ptr; nc = m_cycles; nt = 1'b0;
    if (reset) begin
      nh = -1; np = 0; nc = 0;
    end else if (m_holder < 0) begin
      pick = -1;
      for (int k = 0; k < 5; k++)
        if (pick < 0 && bus.req[(m_ptr + k) % 5]) pick = (m_ptr + k) % 5;
      if (pick >= 0) begin
        nh = pick; nc = 1;
      end
    end else begin
      fin    = bus.release_pulse || !bus.req[m_holder];
      forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
      forced = !fin && (m_cycles >= HOLD);
`endif
      if (fin || forced) begin
        np = (m_holder + 1) % 5; nh = -1; nt = forced;
      end else begin
        nc = m_cycles + 1;
      end
    end
    m_holder <= nh;
    m_ptr    <= np;
    m_cycles <= nc;
    m_to     <= nt;
    if (reset) started <= 1'b1;
    if (started || reset)
      exp_q.push_back({nt, (nh < 0) ? 5'b0 : 5'(1 << nh)});
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // compare process: every cycle once the model has seen reset
  always @(negedge clk) begin : compare
    logic [5:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("model_grant", 32'(bus.grant), 32'(e[4:0]));
      check("model_valid", 32'(bus.grant_valid), 32'(|e[4:0]));
      check("model_timeout", 32'(bus.timeout), 32'(e[5]));
      check("not_multihot", 32'($countones(bus.grant) <= 1), 32'd1);
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] r, input logic rel);
    bus.req           = r;
    bus.release_pulse = rel;
  endtask

  // tail vectors: {req, release}, checked by the model only
  logic [5:0] tail_vec [12] = '{6'b10110_0, 6'b10110_0, 6'b10110_1, 6'b10110_0,
                                6'b00011_0, 6'b00010_0, 6'b11001_1, 6'b11001_0,
                                6'b11001_0, 6'b00000_0, 6'b01100_1, 6'b01100_0};

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(5'b11111, 1'b0);

    // 1: reset with all requests pending
    step(1); check("rst_grant0", 32'(bus.grant), 32'h00);
    check("rst_valid0", 32'(bus.grant_valid), 32'h0);
    step(1); check("rst_grant1", 32'(bus.grant), 32'h00);
    check("rst_state", 32'(dut_state), 32'(IDLE));
    reset = 1'b0;
    step(1); check("first_grant", 32'(bus.grant), 32'h01);
    check("first_valid", 32'(bus.grant_valid), 32'h1);

    // 2: full rotation with wrap
    begin
      logic [4:0] seq [5] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
      for (int i = 0; i < 5; i++) begin
        drive(5'b11111, 1'b1); step(1);
        check("rot_dead", 32'(bus.grant), 32'h00);
        drive(5'b11111, 1'b0); step(1);
        check("rot_grant", 32'(bus.grant), 32'(seq[i]));
      end
    end

    // 3: ptr=3 after serving requester 2, then req=00101
    drive(5'b11111, 1'b1); step(1);
    drive(5'b00100, 1'b0); step(1);
    check("serve2", 32'(bus.grant), 32'h04);
    drive(5'b00101, 1'b1); step(1);
    drive(5'b00101, 1'b0); step(1);
    check("ptr3_pick0", 32'(bus.grant), 32'h01);
    drive(5'b00101, 1'b1); step(1);
    drive(5'b00101, 1'b0); step(1);
    check("then_pick2", 32'(bus.grant), 32'h04);

    // 4: holder 1 drops req without release while req[3] waits
    drive(5'b00010, 1'b1); step(1);
    drive(5'b00010, 1'b0); step(1);
    check("grant1", 32'(bus.grant), 32'h02);
    drive(5'b01010, 1'b0); step(1);
    check("grant1_stable", 32'(bus.grant), 32'h02);
    drive(5'b01000, 1'b0); step(1);
    check("drop_dead", 32'(bus.grant), 32'h00);
    step(1);
    check("grant3", 32'(bus.grant), 32'h08);
    drive(5'b01000, 1'b1); step(1);
    drive(5'b11111, 1'b0); step(1);
    check("ptr4_pick4", 32'(bus.grant), 32'h10);

    // 5: reset during GRANT holding 01000
    drive(5'b01001, 1'b1); step(1);
    drive(5'b01001, 1'b0); step(1);
    check("grant0_again", 32'(bus.grant), 32'h01);
    drive(5'b01000, 1'b0); step(1);
    step(1);
    check("hold3", 32'(bus.grant), 32'h08);
    drive(5'b01001, 1'b0); reset = 1'b1; step(1);
    check("rst_mid", 32'(bus.grant), 32'h00);
    reset = 1'b0; step(1);
    check("after_rst", 32'(bus.grant), 32'h01);

    // 6: long hold of requester 2
    drive(5'b00100, 1'b1); step(1);
    drive(5'b00100, 1'b0); step(1);
    check("hold_c1", 32'(bus.grant), 32'h04);
    step(3);
    check("hold_c4", 32'(bus.grant), 32'h04);
    check("hold_c4_to", 32'(bus.timeout), 32'h0);
    step(1);
`ifdef ARB_TIMEOUT_EN
    check("to_grant", 32'(bus.grant), 32'h00);
    check("to_pulse", 32'(bus.timeout), 32'h1);
    step(1);
    check("to_regrant", 32'(bus.grant), 32'h04);
    check("to_clear", 32'(bus.timeout), 32'h0);
`else
    check("no_to_grant", 32'(bus.grant), 32'h04);
    check("no_to_pulse", 32'(bus.timeout), 32'h0);
    step(10);
    check("no_to_long", 32'(bus.grant), 32'h04);
`endif

    for (int i = 0; i < 12; i++) begin
      drive(tail_vec[i][5:1], tail_vec[i][0]);
      step(1);
    end
    drive(5'b00000, 1'b0);
    step(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
